// File: rtl/video_pixel_pipe.sv
// Pixel colour stage: framebuffer address issue, palette/grayscale/bars/border colouring, sync realignment.
// Latency RD_LAT+2 cycles from x/y to r/g/b; no backpressure, one pixel per clock.
module video_pixel_pipe #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 24,
  parameter int SCALE_SHIFT = 0,
  parameter int RD_LAT      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [1:0]        mode,
  input  logic              border_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              pal_we,
  input  logic [DATA_W-1:0] pal_idx,
  input  logic [23:0]       pal_rgb,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [7:0]        frame_cnt
);
  localparam int DLY   = RD_LAT + 1;
  localparam int PAL_N = 1 << DATA_W;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [9:0] y;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, x: 10'd0, y: 10'd0};

  function automatic logic [7:0] expand(input logic [DATA_W-1:0] v);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[7-i] = v[DATA_W-1-(i % DATA_W)];
    return e;
  endfunction

  logic [1:0]        mode_q;
  logic              vs_prev_q;
  logic [7:0]        frame_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  sync_t             sh_q [DLY];
  logic [23:0]       pal_q [PAL_N];
  logic [23:0]       rgb_q;
  logic              de_q, hs_q, vs_q;

  logic [31:0]       lin_d;
  logic [ADDR_W-1:0] addr_d;
  logic              rd_d;

  always_comb begin
    lin_d  = 32'(y >> SCALE_SHIFT) * 32'(H_ACTIVE >> SCALE_SHIFT) + 32'(x >> SCALE_SHIFT);
    addr_d = BASE_ADDR + ADDR_W'(lin_d);
    rd_d   = de_in & ~mode_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
    end else begin
      mem_rd_q <= rd_d;
      if (rd_d) mem_addr_q <= addr_d;
    end
  end

  // Mode only changes at frame start so a frame never mixes two styles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q <= 1'b1;
      mode_q    <= 2'd0;
      frame_q   <= 8'd0;
    end else begin
      vs_prev_q <= vsync_in;
      if (vs_prev_q && !vsync_in) begin
        mode_q  <= mode;
        frame_q <= frame_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) sh_q[i] <= SYNC_IDLE;
    end else begin
      sh_q[0] <= '{de: de_in, hs: hsync_in, vs: vsync_in, x: x, y: y};
      for (int i = 1; i < DLY; i++) sh_q[i] <= sh_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= {3{expand(DATA_W'(i))}};
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_rgb;
    end
  end

  sync_t       cur;
  logic [2:0]  bar;
  logic        on_edge;
  logic [23:0] rgb_d;

  // Palette lookup reads the pre-write entry when a write lands on the same edge.
  always_comb begin
    cur     = sh_q[DLY-1];
    bar     = 3'(cur.x / 10'(H_ACTIVE / 8));
    on_edge = (cur.x == 10'd0) || (cur.x == 10'(H_ACTIVE - 1)) ||
              (cur.y == 10'd0) || (cur.y == 10'(V_ACTIVE - 1));
    rgb_d   = '0;
    if (!cur.de) begin
      rgb_d = '0;
    end else if (border_en && on_edge) begin
      rgb_d = '1;
    end else begin
      case (mode_q)
        2'd0:    rgb_d = {3{expand(mem_data)}};
        2'd1:    rgb_d = pal_q[mem_data];
        2'd2:    rgb_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
        default: rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      de_q  <= cur.de;
      hs_q  <= cur.hs;
      vs_q  <= cur.vs;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign r         = rgb_q[23:16];
  assign g         = rgb_q[15:8];
  assign b         = rgb_q[7:0];
  assign de_out    = de_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  assign frame_cnt = frame_q;
endmodule

// File: tb/tb_video_pixel_pipe.sv
// Scoreboard bench: per-cycle expected outputs and read addresses are queued at issue and popped by monitors.
module tb_video_pixel_pipe;
  localparam int H = 640, V = 480, DW = 4, AW = 24, RL = 2, L = RL + 2;

  logic clk, rst;
  logic [9:0] x, y;
  logic de_in, hsync_in, vsync_in, border_en, pal_we;
  logic [1:0] mode;
  logic [DW-1:0] pal_idx, mem_data, mem_data1;
  logic [23:0] pal_rgb;
  logic [AW-1:0] mem_addr, mem_addr1;
  logic mem_rd, mem_rd1;
  logic [7:0] r, g, b, r1, g1, b1, frame_cnt, fc1;
  logic de_out, hsync_out, vsync_out, de1, hs1, vs1;

  video_pixel_pipe #(.SCALE_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mode(mode), .border_en(border_en), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb), .r(r), .g(g), .b(b), .de_out(de_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_cnt(frame_cnt));

  video_pixel_pipe #(.SCALE_SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mode(mode), .border_en(border_en), .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_data(mem_data1),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb), .r(r1), .g(g1), .b(b1), .de_out(de1),
    .hsync_out(hs1), .vsync_out(vs1), .frame_cnt(fc1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [3:0] seed;

  // Framebuffer contents: a scrambled function of address, with one pinned pixel.
  function automatic logic [3:0] fbv(input logic [23:0] a);
    logic [23:0] t;
    if (a == 24'd1285) return 4'hA;
    t = (a * 24'd7) ^ (a >> 4);
    return t[3:0] ^ seed;
  endfunction

  logic [DW-1:0] mpipe [RL];
  always @(posedge clk) begin
    mpipe[0] <= fbv(mem_addr);
    for (int i = 1; i < RL; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mem_data  = mpipe[RL-1];
  assign mem_data1 = '0;

  typedef struct { int cyc; logic de; logic hs; logic vs; logic [23:0] rgb; } exp_t;
  typedef struct { int cyc; logic [23:0] a; } aexp_t;
  exp_t  oq[$];
  aexp_t aq0[$], aq1[$];
  exp_t  me;
  aexp_t ma;

  logic [1:0]  mmode;
  logic [7:0]  fcnt_m;
  logic        vs_m;
  logic [23:0] pal_m [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] addr_of(input int xx, input int yy, input int s);
    return 24'((yy >> s) * (H >> s) + (xx >> s));
  endfunction

  function automatic logic [23:0] exp_rgb(input logic de, input int xx, input int yy);
    logic [3:0] d;
    logic [7:0] gv;
    int k;
    if (!de) return 24'h0;
    if (border_en && (xx == 0 || xx == H - 1 || yy == 0 || yy == V - 1)) return 24'hFFFFFF;
    d = fbv(addr_of(xx, yy, 0));
    case (mmode)
      2'd0: begin gv = 8'(d * 17); return {gv, gv, gv}; end
      2'd1: return pal_m[d];
      2'd2: begin
        k = xx / (H / 8);
        return {((k & 4) != 0) ? 8'hFF : 8'h00, ((k & 2) != 0) ? 8'hFF : 8'h00,
                ((k & 1) != 0) ? 8'hFF : 8'h00};
      end
      default: return 24'h0;
    endcase
  endfunction

  task automatic model_reset();
    mmode = 0;
    fcnt_m = 0;
    vs_m = 1;
    for (int i = 0; i < 16; i++) pal_m[i] = {3{8'(i * 17)}};
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs, input int xx, input int yy);
    exp_t e;
    aexp_t a;
    x = 10'(xx); y = 10'(yy); de_in = de; hsync_in = hs; vsync_in = vs;
    e.cyc = cyc + L; e.de = de; e.hs = hs; e.vs = vs; e.rgb = exp_rgb(de, xx, yy);
    oq.push_back(e);
    if (de && mmode < 2) begin
      a.cyc = cyc + 1;
      a.a = addr_of(xx, yy, 0); aq0.push_back(a);
      a.a = addr_of(xx, yy, 1); aq1.push_back(a);
    end
    if (vs_m && !vs) begin
      mmode = mode;
      fcnt_m = fcnt_m + 8'd1;
    end
    vs_m = vs;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1, 1, 0, 0);
  endtask

  task automatic rand_px(input int n);
    for (int i = 0; i < n; i++) begin
      logic de;
      int xx, yy;
      de = ($urandom % 4) != 0;
      if (de) begin
        xx = $urandom % H; yy = $urandom % V;
        if ($urandom % 8 == 0) xx = ($urandom % 2 != 0) ? H - 1 : 0;
        if ($urandom % 8 == 0) yy = ($urandom % 2 != 0) ? V - 1 : 0;
      end else begin
        xx = $urandom % 1024; yy = $urandom % 1024;
      end
      drive(de, de ? 1'b1 : 1'($urandom % 2), 1'b1, xx, yy);
    end
  endtask

  task automatic vpulse(input logic [1:0] m);
    mode = m;
    repeat (L + 1) drive(0, 1'($urandom % 2), 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("frame_cnt", frame_cnt, fcnt_m);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (oq.size() > 0 && oq[0].cyc == cyc) begin
        me = oq.pop_front();
        chk("rgb", {r, g, b}, me.rgb);
        chk("de_hs_vs", {de_out, hsync_out, vsync_out}, {me.de, me.hs, me.vs});
      end else chk("idle_de_out", de_out, 0);
      if (aq0.size() > 0 && aq0[0].cyc == cyc) begin
        ma = aq0.pop_front();
        chk("mem_rd", mem_rd, 1);
        chk("mem_addr", mem_addr, ma.a);
      end else chk("idle_mem_rd", mem_rd, 0);
      if (aq1.size() > 0 && aq1[0].cyc == cyc) begin
        ma = aq1.pop_front();
        chk("mem_rd_s1", mem_rd1, 1);
        chk("mem_addr_s1", mem_addr1, ma.a);
      end else chk("idle_mem_rd_s1", mem_rd1, 0);
    end
  end

  initial begin
    int xp;
    seed = 4'($urandom);
    rst = 1; x = 0; y = 0; de_in = 0; hsync_in = 1; vsync_in = 1; mode = 0;
    border_en = 0; pal_we = 0; pal_idx = 0; pal_rgb = 0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_sync", {hsync_out, vsync_out}, 2'b11);
    chk("rst_de", de_out, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_mem", {mem_rd, mem_addr}, 0);
    rst = 0;

    // Grayscale: pinned pixel, random traffic, scaled line sweep.
    vpulse(0);
    drive(1, 1, 1, 5, 2);
    rand_px(200);
    for (int i = 0; i < 16; i++) drive(1, 1, 1, i, 3);
    drive(0, 0, 1, 700, 3);
    drive(0, 0, 1, 900, 500);

    // Palette: read-first collision on index 3, then random rewrites.
    vpulse(1);
    xp = 1;
    for (int i = 1; i < H - 1; i++) if (fbv(addr_of(i, 10, 0)) == 4'd3) begin xp = i; break; end
    drive(1, 1, 1, xp, 10);
    pal_m[3] = 24'h123456;
    drive(1, 1, 1, xp, 10);
    idle(1);
    pal_we = 1; pal_idx = 3; pal_rgb = 24'h123456;
    idle(1);
    pal_we = 0;
    idle(L);
    repeat (6) begin
      pal_idx = 4'($urandom); pal_rgb = 24'($urandom);
      pal_m[pal_idx] = pal_rgb;
      pal_we = 1; idle(1); pal_we = 0;
    end
    rand_px(150);

    // Mode change mid-frame takes effect only at the next frame.
    vpulse(0);
    rand_px(40);
    mode = 2;
    rand_px(40);
    vpulse(2);
    for (int k = 0; k < 8; k++) drive(1, 1, 1, k * 80 + int'($urandom % 80), int'($urandom_range(1, V - 2)));
    drive(1, 1, 1, 0, 100); drive(1, 1, 1, 79, 100); drive(1, 1, 1, 560, 100); drive(1, 1, 1, 639, 100);
    rand_px(60);

    // Border over blank mode.
    vpulse(3);
    border_en = 1;
    drive(1, 1, 1, 0, 100); drive(1, 1, 1, 639, 100); drive(1, 1, 1, 100, 0); drive(1, 1, 1, 100, 479);
    drive(1, 1, 1, 1, 1); drive(1, 1, 1, 638, 478); drive(1, 1, 1, 320, 240);
    rand_px(100);
    idle(L);
    border_en = 0;

    // Frame counter wrap.
    while (fcnt_m != 8'd0) vpulse(0);

    // Reset in the middle of a line.
    vpulse(1);
    rand_px(20);
    drive(1, 1, 1, 10, 10);
    #2 rst = 1;
    #1;
    chk("mid_rst_rgb", {r, g, b}, 0);
    chk("mid_rst_sync", {hsync_out, vsync_out}, 2'b11);
    chk("mid_rst_de", de_out, 0);
    chk("mid_rst_frame", frame_cnt, 0);
    chk("mid_rst_mem", {mem_rd, mem_addr}, 0);
    oq.delete(); aq0.delete(); aq1.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    drive(1, 1, 1, 5, 2);
    rand_px(60);

    idle(L + 1);
    repeat (L + 1) @(posedge clk);
    #1;
    chk("queues_drained", oq.size() + aq0.size() + aq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
